// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: five-mode LED pattern stepper with tick prescaler, pause and mode advance.
// Define LED_SEQ_AUTO_EN to auto-advance the mode after g_AUTO_STEPS ticks.
module led_pattern_sequencer #(
    parameter int g_TICK_COUNT = 2_500_000,
    parameter int g_AUTO_STEPS = 32
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Next,
    input  logic       i_Pause,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [2:0] o_Mode,
    output logic       o_Tick
);
    localparam logic [2:0] OFF = 3'd0, CHASE = 3'd1, BOUNCE = 3'd2, BINARY = 3'd3, BLINK = 3'd4;
    localparam int PW = $clog2(g_TICK_COUNT);

    logic [2:0]    mode_q, mode_d;
    logic [3:0]    step_q, step_d, step_last, led_q, led_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          paused_q, paused_d, tick_q, tick_d, term, adv, auto_adv;

    assign term   = pre_q == PW'(g_TICK_COUNT - 1);
    assign tick_d = !paused_q && term && !i_Next;
    assign adv    = i_Next || auto_adv;

`ifdef LED_SEQ_AUTO_EN
    localparam int AW = $clog2(g_AUTO_STEPS + 1);
    logic [AW-1:0] auto_q, auto_d;
    assign auto_adv = tick_d && auto_q == AW'(g_AUTO_STEPS - 1);
    assign auto_d   = adv ? '0 : tick_d ? auto_q + AW'(1) : auto_q;
    always_ff @(posedge i_Clk or negedge i_Rst_L)
        if (!i_Rst_L) auto_q <= '0;
        else          auto_q <= auto_d;
`else
    logic unused_auto;
    assign unused_auto = ^g_AUTO_STEPS;
    assign auto_adv    = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            mode_q   <= OFF;
            step_q   <= '0;
            pre_q    <= '0;
            paused_q <= 1'b0;
            tick_q   <= 1'b0;
            led_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            step_q   <= step_d;
            pre_q    <= pre_d;
            paused_q <= paused_d;
            tick_q   <= tick_d;
            led_q    <= led_d;
        end
    end

    // Illegal encodings fall back to OFF regardless of any pending advance.
    always_comb begin
        step_last = mode_q == CHASE  ? 4'd3  :
                    mode_q == BOUNCE ? 4'd5  :
                    mode_q == BINARY ? 4'd15 :
                    mode_q == BLINK  ? 4'd1  : 4'd0;
        mode_d    = mode_q > BLINK ? OFF :
                    !adv ? mode_q :
                    mode_q == BLINK ? OFF : mode_q + 3'd1;
        step_d    = adv ? '0 : !tick_d ? step_q : step_q >= step_last ? '0 : step_q + 4'd1;
        pre_d     = adv ? '0 : paused_q ? pre_q : term ? '0 : pre_q + PW'(1);
        paused_d  = paused_q ^ i_Pause;
    end

    always_comb begin
        led_d = mode_q == CHASE  ? 4'b0001 << step_q[1:0] :
                mode_q == BOUNCE ? (step_q < 4'd4 ? 4'b0001 << step_q[1:0] :
                                    step_q == 4'd4 ? 4'b0100 : 4'b0010) :
                mode_q == BINARY ? step_q :
                mode_q == BLINK  ? {4{step_q[0]}} : 4'b0000;
    end

    assign {o_LED_4, o_LED_3, o_LED_2, o_LED_1} = led_q;
    assign o_Mode = mode_q;
    assign o_Tick = tick_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed checks of modes, stepping, pause, next priority and reset.
module tb_led_pattern_sequencer;
    logic       i_Clk = 1'b0, i_Rst_L = 1'b0, i_Next = 1'b0, i_Pause = 1'b0;
    logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Tick;
    logic [2:0] o_Mode;
    logic [3:0] leds;
    int         checks = 0, failures = 0;

    led_pattern_sequencer #(.g_TICK_COUNT(4), .g_AUTO_STEPS(3)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Next(i_Next), .i_Pause(i_Pause),
        .o_LED_1(o_LED_1), .o_LED_2(o_LED_2), .o_LED_3(o_LED_3), .o_LED_4(o_LED_4),
        .o_Mode(o_Mode), .o_Tick(o_Tick)
    );

    always #5 i_Clk = ~i_Clk;
    assign leds = {o_LED_4, o_LED_3, o_LED_2, o_LED_1};

    task automatic clk1();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            clk1();
            n++;
        end while (!o_Tick && n < 12);
    endtask

    task automatic do_reset();
        i_Rst_L = 1'b0;
        #2;
        i_Rst_L = 1'b1;
    endtask

    task automatic test_reset();
        clk1();
        clk1();
        checks++;
        if ({o_Mode, leds, o_Tick} !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got mode=%0d leds=%b tick=%b exp mode=0 leds=0000 tick=0", o_Mode, leds, o_Tick);
        end
        i_Rst_L = 1'b1;
    endtask

`ifndef LED_SEQ_AUTO_EN
    task automatic test_idle();
        for (int c = 1; c <= 20; c++) begin
            clk1();
            checks++;
            if (o_Tick !== (c % 4 == 0)) begin
                failures++;
                $display("FAIL idle_tick cycle=%0d got=%b exp=%b", c, o_Tick, c % 4 == 0);
            end
        end
        checks++;
        if (o_Mode !== 3'd0 || leds !== 4'b0000) begin
            failures++;
            $display("FAIL idle_state got mode=%0d leds=%b exp mode=0 leds=0000", o_Mode, leds);
        end
    endtask

    task automatic test_chase();
        logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int n;
        i_Next = 1'b1;
        clk1();
        i_Next = 1'b0;
        checks++;
        if (o_Mode !== 3'd1 || o_Tick !== 1'b0) begin
            failures++;
            $display("FAIL chase_enter got mode=%0d tick=%b exp mode=1 tick=0", o_Mode, o_Tick);
        end
        clk1();
        checks++;
        if (leds !== exp[0]) begin
            failures++;
            $display("FAIL chase_led0 got=%b exp=%b", leds, exp[0]);
        end
        for (int k = 1; k < 5; k++) begin
            wait_tick(n);
            checks++;
            if (o_Tick !== 1'b1 || n != 3) begin
                failures++;
                $display("FAIL chase_tick k=%0d got tick=%b after %0d clk exp tick=1 after 3 clk", k, o_Tick, n);
            end
            clk1();
            checks++;
            if (leds !== exp[k] || o_Mode !== 3'd1) begin
                failures++;
                $display("FAIL chase_led k=%0d got leds=%b mode=%0d exp leds=%b mode=1", k, leds, o_Mode, exp[k]);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        int n;
        i_Next = 1'b1;
        clk1();
        i_Next = 1'b0;
        checks++;
        if (o_Mode !== 3'd2) begin
            failures++;
            $display("FAIL bounce_mode got=%0d exp=2", o_Mode);
        end
        clk1();
        checks++;
        if (leds !== exp[0]) begin
            failures++;
            $display("FAIL bounce_led0 got=%b exp=%b", leds, exp[0]);
        end
        for (int k = 1; k < 7; k++) begin
            wait_tick(n);
            checks++;
            if (o_Tick !== 1'b1 || n != 3) begin
                failures++;
                $display("FAIL bounce_tick k=%0d got tick=%b after %0d clk exp tick=1 after 3 clk", k, o_Tick, n);
            end
            clk1();
            checks++;
            if (leds !== exp[k]) begin
                failures++;
                $display("FAIL bounce_led k=%0d got=%b exp=%b", k, leds, exp[k]);
            end
        end
    endtask

    task automatic test_pause();
        int n;
        do_reset();
        i_Next = 1'b1;
        clk1();
        i_Next = 1'b0;
        clk1();
        wait_tick(n);
        clk1();
        checks++;
        if (leds !== 4'b0010 || o_Mode !== 3'd1) begin
            failures++;
            $display("FAIL pause_setup got leds=%b mode=%0d exp leds=0010 mode=1", leds, o_Mode);
        end
        i_Pause = 1'b1;
        clk1();
        i_Pause = 1'b0;
        for (int c = 0; c < 20; c++) begin
            clk1();
            checks++;
            if (o_Tick !== 1'b0 || leds !== 4'b0010) begin
                failures++;
                $display("FAIL pause_frozen cycle=%0d got tick=%b leds=%b exp tick=0 leds=0010", c, o_Tick, leds);
            end
        end
        i_Pause = 1'b1;
        clk1();
        i_Pause = 1'b0;
        wait_tick(n);
        checks++;
        if (o_Tick !== 1'b1 || n != 2) begin
            failures++;
            $display("FAIL pause_resume got tick=%b after %0d clk exp tick=1 after 2 clk", o_Tick, n);
        end
        clk1();
        checks++;
        if (leds !== 4'b0100) begin
            failures++;
            $display("FAIL pause_resume_led got=%b exp=0100", leds);
        end
    endtask

    task automatic test_binary_next();
        int n;
        do_reset();
        i_Next = 1'b1;
        clk1();
        clk1();
        clk1();
        i_Next = 1'b0;
        wait_tick(n);
        wait_tick(n);
        clk1();
        checks++;
        if (o_Mode !== 3'd3 || leds !== 4'b0010) begin
            failures++;
            $display("FAIL binary_step2 got mode=%0d leds=%b exp mode=3 leds=0010", o_Mode, leds);
        end
        clk1();
        clk1();
        i_Next = 1'b1;
        clk1();
        i_Next = 1'b0;
        checks++;
        if (o_Mode !== 3'd4 || o_Tick !== 1'b0 || leds !== 4'b0010) begin
            failures++;
            $display("FAIL next_at_terminal got mode=%0d tick=%b leds=%b exp mode=4 tick=0 leds=0010", o_Mode, o_Tick, leds);
        end
        clk1();
        checks++;
        if (leds !== 4'b0000 || o_Tick !== 1'b0) begin
            failures++;
            $display("FAIL blink_enter got leds=%b tick=%b exp leds=0000 tick=0", leds, o_Tick);
        end
        wait_tick(n);
        clk1();
        checks++;
        if (leds !== 4'b1111) begin
            failures++;
            $display("FAIL blink_on got=%b exp=1111", leds);
        end
        wait_tick(n);
        checks++;
        if (o_Tick !== 1'b1 || leds !== 4'b1111 || o_Mode !== 3'd4) begin
            failures++;
            $display("FAIL blink_pre_reset got tick=%b leds=%b mode=%0d exp tick=1 leds=1111 mode=4", o_Tick, leds, o_Mode);
        end
        i_Rst_L = 1'b0;
        #2;
        checks++;
        if ({o_Mode, leds, o_Tick} !== 8'h00) begin
            failures++;
            $display("FAIL async_reset got mode=%0d leds=%b tick=%b exp all 0", o_Mode, leds, o_Tick);
        end
        i_Rst_L = 1'b1;
    endtask

    task automatic test_no_auto();
        do_reset();
        for (int c = 0; c < 100; c++) begin
            clk1();
            checks++;
            if (o_Mode !== 3'd0) begin
                failures++;
                $display("FAIL no_auto cycle=%0d got mode=%0d exp=0", c, o_Mode);
            end
        end
    endtask
`else
    task automatic test_auto();
        int n;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            wait_tick(n);
            checks++;
            if (o_Tick !== 1'b1 || n != 4 || o_Mode !== 3'(k / 3)) begin
                failures++;
                $display("FAIL auto_tick k=%0d got tick=%b n=%0d mode=%0d exp tick=1 n=4 mode=%0d", k, o_Tick, n, o_Mode, k / 3);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef LED_SEQ_AUTO_EN
        test_auto();
`else
        test_idle();
        test_chase();
        test_bounce();
        test_pause();
        test_binary_next();
        test_no_auto();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
